// File: rtl/ha_array_reduce_pipe.sv
// Two-stage valid/ready reduction of the approximate multiplier's half-adder rows into a 16-bit product.
// Optional macro HA_REDUCE_TXN_CNT_EN adds the txn_cnt/sat_cnt handshake counters.
`timescale 1ns/1ps
module ha_array_reduce_pipe #(
  parameter int OUT_W          = 16,
  parameter bit SAT_EN_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [6:0]       ha_array_1_b,
  input  logic [8:0]       ha_array_1_t,
  input  logic [6:0]       ha_array_2_b,
  input  logic [8:0]       ha_array_2_t,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_3_t,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product,
  output logic             sat
`ifdef HA_REDUCE_TXN_CNT_EN
  ,
  output logic [15:0]      txn_cnt,
  output logic [7:0]       sat_cnt
`endif
);

  localparam int SUM_W = OUT_W + 1;

  // Row k value before its 2k shift: sums at weight 2^i, carries at weight 2^(j+2).
  function automatic logic [SUM_W-1:0] row_value(input logic [8:0] t, input logic [6:0] b);
    return SUM_W'(t) + SUM_W'({b, 2'b00});
  endfunction

  logic [SUM_W-1:0] r0, r1, r2, r3;
  logic [SUM_W-1:0] sum17;
  logic [12:0]      s1_lo;
  logic [SUM_W-1:0] s1_hi;
  logic             s1_sat_en;
  logic             s1_valid;
  logic             s2_ready;
  logic             s1_advance;
  logic             accept;

  assign r0 = row_value(ha_array_0_t, ha_array_0_b);
  assign r1 = row_value(ha_array_1_t, ha_array_1_b) << 2;
  assign r2 = row_value(ha_array_2_t, ha_array_2_b) << 4;
  assign r3 = row_value(ha_array_3_t, ha_array_3_b) << 6;

  assign s2_ready   = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_ready;
  assign accept     = in_valid && in_ready;
  assign s1_advance = s1_valid && s2_ready;
  assign sum17      = SUM_W'(s1_lo) + s1_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_lo     <= '0;
      s1_hi     <= '0;
      s1_sat_en <= SAT_EN_DEFAULT;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_lo     <= 13'(r0 + r1);
        s1_hi     <= r2 + r3;
        s1_sat_en <= sat_en;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Output register only reloads on an advance, so a stalled product stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      product   <= '0;
      sat       <= 1'b0;
    end else begin
      if (s1_advance) begin
        out_valid <= 1'b1;
        sat       <= sum17[SUM_W-1];
        if (sum17[SUM_W-1] && s1_sat_en)
          product <= '1;
        else
          product <= sum17[OUT_W-1:0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef HA_REDUCE_TXN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_cnt <= '0;
      sat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      txn_cnt <= txn_cnt + 16'd1;
      if (sat && sat_cnt != 8'hFF)
        sat_cnt <= sat_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ha_array_reduce_pipe.sv
// Table vectors, directed multi-cycle sequences and randomized traffic against an arithmetic scoreboard.
`timescale 1ns/1ps
module tb_ha_array_reduce_pipe;

  typedef struct {
    logic [6:0]  b0, b1, b2, b3;
    logic [8:0]  t0, t1, t2, t3;
    logic        se;
    logic [15:0] product;
    logic        sat;
  } vec_t;

  typedef struct {
    logic [15:0] product;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, sat_en, sat;
  logic [6:0]  b0, b1, b2, b3;
  logic [8:0]  t0, t1, t2, t3;
  logic [15:0] product;
`ifdef HA_REDUCE_TXN_CNT_EN
  logic [15:0] txn_cnt;
  logic [7:0]  sat_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  int   hs_total = 0;
  int   sat_model = 0;
  exp_t exp_q[$];
  vec_t vecs[8];
  vec_t bp[4];

  ha_array_reduce_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ha_array_0_b(b0), .ha_array_0_t(t0), .ha_array_1_b(b1), .ha_array_1_t(t1),
    .ha_array_2_b(b2), .ha_array_2_t(t2), .ha_array_3_b(b3), .ha_array_3_t(t3),
    .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .sat(sat)
`ifdef HA_REDUCE_TXN_CNT_EN
    , .txn_cnt(txn_cnt), .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference: weigh every set bit directly and apply the overflow rule on the integer total.
  function automatic exp_t model(input vec_t v);
    logic [6:0] bb[4];
    logic [8:0] tt[4];
    int total = 0;
    exp_t e;
    bb[0] = v.b0; bb[1] = v.b1; bb[2] = v.b2; bb[3] = v.b3;
    tt[0] = v.t0; tt[1] = v.t1; tt[2] = v.t2; tt[3] = v.t3;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) if (tt[k][i]) total += 1 << (2*k + i);
      for (int j = 0; j < 7; j++) if (bb[k][j]) total += 1 << (2*k + j + 2);
    end
    e.sat = (total > 65535);
    if (total > 65535) e.product = v.se ? 16'hFFFF : 16'(total - 65536);
    else e.product = 16'(total);
    return e;
  endfunction

  function automatic vec_t mk(input logic [6:0] xb0, input logic [8:0] xt0,
                              input logic [6:0] xb1, input logic [8:0] xt1,
                              input logic [6:0] xb2, input logic [8:0] xt2,
                              input logic [6:0] xb3, input logic [8:0] xt3,
                              input logic xse, input logic [15:0] xp, input logic xs);
    vec_t v;
    v.b0 = xb0; v.t0 = xt0; v.b1 = xb1; v.t1 = xt1;
    v.b2 = xb2; v.t2 = xt2; v.b3 = xb3; v.t3 = xt3;
    v.se = xse; v.product = xp; v.sat = xs;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    if ($urandom_range(4) == 0)
      v = mk(7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 1'b0, 16'd0, 1'b0);
    else
      v = mk(7'($urandom), 9'($urandom), 7'($urandom), 9'($urandom),
             7'($urandom), 9'($urandom), 7'($urandom), 9'($urandom), 1'b0, 16'd0, 1'b0);
    v.se = 1'($urandom_range(1));
    return v;
  endfunction

  function automatic vec_t current_inputs();
    return mk(b0, t0, b1, t1, b2, t2, b3, t3, sat_en, 16'd0, 1'b0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic driveVec(input vec_t v);
    b0 = v.b0; t0 = v.t0; b1 = v.b1; t1 = v.t1;
    b2 = v.b2; t2 = v.t2; b3 = v.b3; t3 = v.t3;
    sat_en = v.se;
  endtask

  // Present a vector, wait (bounded) for its accept edge, and return 1ns after that edge.
  task automatic applyStimulus(input vec_t v);
    bit got = 0;
    driveVec(v);
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      else @(posedge clk);
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout got 0 expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic waitOutput(output bit ok);
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL output_timeout got 0 expected 1");
    end
  endtask

  // Scoreboard: inputs are stable from negedge to the next posedge, so handshakes are judged here.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hs_total  = 0;
      sat_model = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected got %0d expected none", product);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("sb_product", product, e.product);
          checkOutput("sb_sat", sat, e.sat);
          hs_total++;
          if (e.sat && sat_model < 255) sat_model++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(current_inputs()));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int hs_before;
    logic [15:0] held;

    vecs[0] = mk(0, 9'h001, 0, 0, 0, 0, 0, 0, 1'b1, 16'd1, 1'b0);
    vecs[1] = mk(0, 0, 7'h01, 0, 0, 0, 0, 0, 1'b1, 16'd16, 1'b0);
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 7'h40, 0, 1'b1, 16'd16384, 1'b0);
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 7'h7F, 9'h1FF, 1'b1, 16'd65216, 1'b0);
    vecs[4] = mk(7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 1'b1, 16'hFFFF, 1'b1);
    vecs[5] = mk(7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 1'b0, 16'd21079, 1'b1);
    vecs[6] = mk(0, 0, 0, 0, 0, 9'h100, 0, 0, 1'b0, 16'd4096, 1'b0);
    vecs[7] = mk(7'h40, 0, 0, 0, 0, 0, 0, 0, 1'b1, 16'd256, 1'b0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    driveVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 16'd0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_product", product, 0);
    checkOutput("rst_sat", sat, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency: accept edge N, out_valid visible after N+1, consumed at N+2.
    applyStimulus(vecs[0]);
    checkOutput("lat_edge_n", out_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("lat_edge_n1", out_valid, 1);
    checkOutput("lat_product", product, 1);
    @(posedge clk);
    #1;
    checkOutput("lat_drained", out_valid, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      waitOutput(ok);
      if (ok) begin
        checkOutput($sformatf("tbl%0d_product", i), product, vecs[i].product);
        checkOutput($sformatf("tbl%0d_sat", i), sat, vecs[i].sat);
      end
      @(posedge clk);
      #1;
    end

    // Backpressure: two accepts fill the pipe, the rest wait until out_ready returns.
    for (int i = 0; i < 4; i++) bp[i] = rand_vec();
    hs_before = hs_total;
    out_ready = 1'b0;
    applyStimulus(bp[0]);
    checkOutput("bp_ready_after1", in_ready, 1);
    applyStimulus(bp[1]);
    checkOutput("bp_ready_after2", in_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_head", product, model(bp[0]).product);
    held = product;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_held", product, held);
    checkOutput("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    applyStimulus(bp[2]);
    applyStimulus(bp[3]);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("bp_count", hs_total - hs_before, 4);
    checkOutput("bp_queue_empty", exp_q.size(), 0);

    for (int c = 0; c < 400; c++) begin
      driveVec(rand_vec());
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(9) < 7);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("rand_queue_empty", exp_q.size(), 0);
`ifdef HA_REDUCE_TXN_CNT_EN
    checkOutput("txn_cnt", txn_cnt, 32'(hs_total[15:0]));
    checkOutput("sat_cnt", sat_cnt, sat_model);
`endif

    // Reset while both stages hold data: everything in flight must vanish.
    out_ready = 1'b0;
    applyStimulus(rand_vec());
    applyStimulus(rand_vec());
    checkOutput("mid_full", in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_product", product, 0);
    checkOutput("mid_rst_sat", sat, 0);
`ifdef HA_REDUCE_TXN_CNT_EN
    checkOutput("mid_rst_txn_cnt", txn_cnt, 0);
    checkOutput("mid_rst_sat_cnt", sat_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("mid_rel_in_ready", in_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mid_rel_no_output", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
